// File: rtl/latency_aligned_driver_if.sv
// Bus between the latency-aligned operand driver, the DUT-side harness and the monitor.
// o_aligned_valid qualifies o_drive_delayed_*; there is no ready, since the monitor samples every cycle.
interface latency_aligned_driver_if #(
    parameter int WIDTH = 32
);
    logic             i_recal;
    logic [WIDTH-1:0] i_rand_a;
    logic [WIDTH-1:0] i_rand_b;
    logic [WIDTH-1:0] i_dut_out;
    logic [WIDTH-1:0] o_drive_a;
    logic [WIDTH-1:0] o_drive_b;
    logic [WIDTH-1:0] o_drive_delayed_a;
    logic [WIDTH-1:0] o_drive_delayed_b;
    logic [31:0]      o_dut_delay;
    logic             o_cal_done;
    logic             o_cal_error;
    logic             o_aligned_valid;
    logic [4:0]       dbg_state;

    modport master (
        input  i_recal, i_rand_a, i_rand_b, i_dut_out,
        output o_drive_a, o_drive_b, o_drive_delayed_a, o_drive_delayed_b,
        output o_dut_delay, o_cal_done, o_cal_error, o_aligned_valid, dbg_state
    );

    modport slave (
        output i_recal, i_rand_a, i_rand_b, i_dut_out,
        input  o_drive_a, o_drive_b, o_drive_delayed_a, o_drive_delayed_b,
        input  o_dut_delay, o_cal_done, o_cal_error, o_aligned_valid, dbg_state
    );
endinterface

// File: rtl/latency_aligned_driver.sv
// Drives LFSR operands into the DUT, measures its pipeline latency with one zero marker,
// and re-aligns the operands to that latency through a selectable-tap delay line.
module latency_aligned_driver #(
    parameter int WIDTH   = 32,
    parameter int ARM_W   = 4,
    parameter int MAX_LAT = 15
) (
    input logic clk_dut,
    input logic reset,
    latency_aligned_driver_if.master bus
);
    localparam int LAT_W = (MAX_LAT < 1) ? 1 : $clog2(MAX_LAT + 1);

    localparam logic [4:0] S_IDLE  = 5'b00001;
    localparam logic [4:0] S_ARM   = 5'b00010;
    localparam logic [4:0] S_COUNT = 5'b00100;
    localparam logic [4:0] S_DONE  = 5'b01000;
    localparam logic [4:0] S_ERROR = 5'b10000;

    localparam logic [LAT_W-1:0] LAT_MAX = LAT_W'(MAX_LAT);

    logic [4:0]       state, state_nxt;
    logic [ARM_W-1:0] arm_cnt;
    logic [LAT_W-1:0] lat, lat_nxt;
    logic [LAT_W-1:0] l_q, l_nxt;
    logic             marker;
    logic             dut_zero;
    logic             in_done;

    // tap_*[0] is the drive register itself; tap_*[n] is the drive value n cycles ago.
    logic [WIDTH-1:0] tap_a [0:MAX_LAT];
    logic [WIDTH-1:0] tap_b [0:MAX_LAT];

    assign marker   = (state == S_ARM) && (&arm_cnt);
    assign dut_zero = (bus.i_dut_out == '0);
    assign in_done  = (state == S_DONE);

    always_comb begin
        state_nxt = state;
        lat_nxt   = lat;
        l_nxt     = l_q;
        if (bus.i_recal) begin
            state_nxt = S_IDLE;
            lat_nxt   = '0;
            l_nxt     = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!dut_zero) state_nxt = S_ARM;
                end
                S_ARM: begin
                    lat_nxt = '0;
                    if (&arm_cnt) state_nxt = S_COUNT;
                end
                S_COUNT: begin
                    // A zero on the last countable cycle still counts as a hit.
                    if (dut_zero) begin
                        state_nxt = S_DONE;
                        l_nxt     = lat;
                    end else if (lat == LAT_MAX) begin
                        state_nxt = S_ERROR;
                    end else begin
                        lat_nxt = lat + LAT_W'(1);
                    end
                end
                S_DONE:  state_nxt = S_DONE;
                S_ERROR: state_nxt = S_ERROR;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_dut) begin
        if (reset) begin
            state   <= S_IDLE;
            arm_cnt <= '0;
            lat     <= '0;
            l_q     <= '0;
            for (int n = 0; n <= MAX_LAT; n++) begin
                tap_a[n] <= '0;
                tap_b[n] <= '0;
            end
        end else begin
            state   <= state_nxt;
            arm_cnt <= arm_cnt + ARM_W'(1);
            lat     <= lat_nxt;
            l_q     <= l_nxt;
            tap_a[0] <= marker ? '0 : bus.i_rand_a;
            tap_b[0] <= marker ? '0 : bus.i_rand_b;
            for (int n = 1; n <= MAX_LAT; n++) begin
                tap_a[n] <= tap_a[n-1];
                tap_b[n] <= tap_b[n-1];
            end
        end
    end

    assign bus.o_drive_a         = tap_a[0];
    assign bus.o_drive_b         = tap_b[0];
    assign bus.o_drive_delayed_a = in_done ? tap_a[l_q] : '0;
    assign bus.o_drive_delayed_b = in_done ? tap_b[l_q] : '0;
    assign bus.o_dut_delay       = in_done ? 32'(l_q) : 32'hFFFF_FFFF;
    assign bus.o_cal_done        = in_done;
    assign bus.o_cal_error       = (state == S_ERROR);
    assign bus.o_aligned_valid   = in_done;
    assign bus.dbg_state         = state;
endmodule

// File: tb/tb_latency_aligned_driver.sv
// Bench for latency_aligned_driver: a variable-depth adder model closes the loop and a
// history of applied operands predicts the driven and re-aligned values.
module tb_latency_aligned_driver;
    localparam int WIDTH   = 32;
    localparam int ARM_W   = 4;
    localparam int MAX_LAT = 15;

    logic clk_dut = 1'b0;
    logic reset;
    always #5 clk_dut = ~clk_dut;

    latency_aligned_driver_if #(.WIDTH(WIDTH)) bus();

    latency_aligned_driver #(
        .WIDTH(WIDTH), .ARM_W(ARM_W), .MAX_LAT(MAX_LAT)
    ) dut (
        .clk_dut(clk_dut),
        .reset(reset),
        .bus(bus)
    );

    // Adder DUT model: depth 0 is combinational, depth d registers the sum d times.
    int depth = 3;
    logic [WIDTH-1:0] pipe [0:31];
    always_ff @(posedge clk_dut) begin
        pipe[0] <= bus.o_drive_a + bus.o_drive_b;
        for (int n = 1; n < 32; n++) pipe[n] <= pipe[n-1];
    end
    always_comb bus.i_dut_out = (depth == 0) ? (bus.o_drive_a + bus.o_drive_b) : pipe[depth-1];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [WIDTH-1:0] hist_a[$];
    logic [WIDTH-1:0] hist_b[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: new operands applied just after the edge, returns at the sampling edge.
    task automatic step();
        @(posedge clk_dut);
        #1;
        bus.i_rand_a = $urandom;
        bus.i_rand_b = $urandom;
        hist_a.push_back(bus.i_rand_a);
        hist_b.push_back(bus.i_rand_b);
        cyc++;
        @(negedge clk_dut);
    endtask

    task automatic pulse_recal();
        bus.i_recal = 1'b1;
        step();
        bus.i_recal = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_drive_a"}, 64'(bus.o_drive_a), 64'd0);
        chk({tag, "_drive_b"}, 64'(bus.o_drive_b), 64'd0);
        chk({tag, "_dly_a"}, 64'(bus.o_drive_delayed_a), 64'd0);
        chk({tag, "_dly_b"}, 64'(bus.o_drive_delayed_b), 64'd0);
        chk({tag, "_dut_delay"}, 64'(bus.o_dut_delay), 64'hFFFF_FFFF);
        chk({tag, "_cal_done"}, 64'(bus.o_cal_done), 64'd0);
        chk({tag, "_cal_error"}, 64'(bus.o_cal_error), 64'd0);
        chk({tag, "_valid"}, 64'(bus.o_aligned_valid), 64'd0);
    endtask

    // Runs until done or error; elapsed = cycles from marker on o_drive_* to the flag.
    task automatic wait_cal(input string tag, output int elapsed);
        int marker_cyc;
        logic finished;
        marker_cyc = -1;
        elapsed    = -1;
        finished   = 1'b0;
        for (int i = 0; i < 300; i++) begin
            step();
            if (marker_cyc < 0 && bus.o_drive_a == '0 && bus.o_drive_b == '0) marker_cyc = cyc;
            if (bus.o_cal_done || bus.o_cal_error) begin
                finished = 1'b1;
                elapsed  = (marker_cyc < 0) ? -2 : cyc - marker_cyc;
                break;
            end
        end
        chk({tag, "_finished"}, 64'(finished), 64'd1);
    endtask

    task automatic calibrate(input string tag, input int d);
        int elapsed;
        wait_cal(tag, elapsed);
        chk({tag, "_cal_done"}, 64'(bus.o_cal_done), 64'd1);
        chk({tag, "_cal_error"}, 64'(bus.o_cal_error), 64'd0);
        chk({tag, "_dut_delay"}, 64'(bus.o_dut_delay), 64'(d));
        chk({tag, "_elapsed"}, 64'(elapsed), 64'(d + 1));
    endtask

    task automatic check_aligned(input string tag, input int n, input int l);
        logic [WIDTH-1:0] sum;
        for (int i = 0; i < n; i++) begin
            step();
            sum = bus.o_drive_delayed_a + bus.o_drive_delayed_b;
            chk({tag, "_sum"}, 64'(sum), 64'(bus.i_dut_out));
            chk({tag, "_drive_a"}, 64'(bus.o_drive_a), 64'(hist_a[hist_a.size()-2]));
            chk({tag, "_drive_b"}, 64'(bus.o_drive_b), 64'(hist_b[hist_b.size()-2]));
            chk({tag, "_dly_a"}, 64'(bus.o_drive_delayed_a), 64'(hist_a[hist_a.size()-2-l]));
            chk({tag, "_dly_b"}, 64'(bus.o_drive_delayed_b), 64'(hist_b[hist_b.size()-2-l]));
            chk({tag, "_valid"}, 64'(bus.o_aligned_valid), 64'd1);
        end
    endtask

    initial begin
        int elapsed;
        logic seen;
        reset        = 1'b1;
        bus.i_recal  = 1'b0;
        bus.i_rand_a = '0;
        bus.i_rand_b = '0;

        // Reset state, then first calibration against a 3-stage adder.
        step();
        step();
        check_reset_values("reset");
        reset = 1'b0;
        calibrate("depth3", 3);
        chk("depth3_valid", 64'(bus.o_aligned_valid), 64'd1);
        check_aligned("depth3", 1000, 3);

        // Combinational adder.
        depth = 0;
        pulse_recal();
        chk("recal0_done_drop", 64'(bus.o_cal_done), 64'd0);
        chk("recal0_valid_drop", 64'(bus.o_aligned_valid), 64'd0);
        calibrate("depth0", 0);
        check_aligned("depth0", 50, 0);

        // Too deep: expect ERROR after 16 counting cycles.
        depth = 20;
        pulse_recal();
        wait_cal("depth20", elapsed);
        chk("depth20_cal_error", 64'(bus.o_cal_error), 64'd1);
        chk("depth20_cal_done", 64'(bus.o_cal_done), 64'd0);
        chk("depth20_elapsed", 64'(elapsed), 64'(MAX_LAT + 1));
        for (int i = 0; i < 5; i++) begin
            step();
            chk("depth20_hold_error", 64'(bus.o_cal_error), 64'd1);
            chk("depth20_dut_delay", 64'(bus.o_dut_delay), 64'hFFFF_FFFF);
            chk("depth20_dly_a", 64'(bus.o_drive_delayed_a), 64'd0);
            chk("depth20_dly_b", 64'(bus.o_drive_delayed_b), 64'd0);
            chk("depth20_valid", 64'(bus.o_aligned_valid), 64'd0);
        end

        // Boundary: latency equals MAX_LAT.
        depth = 15;
        pulse_recal();
        chk("recal15_error_drop", 64'(bus.o_cal_error), 64'd0);
        calibrate("depth15", 15);
        check_aligned("depth15", 30, 15);

        // Depth 2, then switch to 5 and recalibrate.
        depth = 2;
        pulse_recal();
        calibrate("depth2", 2);
        check_aligned("depth2", 20, 2);
        depth = 5;
        pulse_recal();
        chk("recal5_done_drop", 64'(bus.o_cal_done), 64'd0);
        chk("recal5_dut_delay", 64'(bus.o_dut_delay), 64'hFFFF_FFFF);
        calibrate("depth5", 5);
        check_aligned("depth5", 100, 5);

        // Reset in the middle of COUNT, together with recal.
        depth = 8;
        pulse_recal();
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (bus.o_drive_a == '0 && bus.o_drive_b == '0) begin
                seen = 1'b1;
                break;
            end
        end
        chk("midcount_marker_seen", 64'(seen), 64'd1);
        step();
        step();
        step();
        reset       = 1'b1;
        bus.i_recal = 1'b1;
        step();
        check_reset_values("midcount_reset");
        step();
        check_reset_values("midcount_reset_hold");
        reset       = 1'b0;
        bus.i_recal = 1'b0;
        depth = 4;
        calibrate("after_reset", 4);
        check_aligned("after_reset", 50, 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/latency_aligned_driver.md
# latency_aligned_driver

Parametrised operand driver for the arithmetic testbench: applies LFSR operands to the DUT on `clk_dut` and measures DUT pipeline latency once with a single zero marker. It then supplies the monitor with operands re-aligned to that measured latency through a selectable-tap delay line. It sits between the LFSR pair and the DUT/monitor and replaces the fixed two-stage delay with a run-time calibrated one that supports recalibration and timeout detection.

## Interface
- `WIDTH`, 32, operand and DUT result width
- `ARM_W`, 4, arming counter width; the marker is injected on the first wrap of this counter in ARM
- `MAX_LAT`, 15, largest measurable latency in cycles; the delay line has `MAX_LAT+1` taps
- `clk_dut`  in  1  sole clock; all logic on its rising edge
- `reset`  in  1  synchronous, active-high reset
- `i_recal`  in  1  level/pulse; restarts calibration
- `i_rand_a`, `i_rand_b`  in  WIDTH  LFSR operands
- `i_dut_out`  in  WIDTH  DUT result
- `o_drive_a`, `o_drive_b`  out  WIDTH  registered operands to DUT (`a_0`/`b_0`)
- `o_drive_delayed_a`, `o_drive_delayed_b`  out  WIDTH  operands aligned with `i_dut_out`
- `o_dut_delay`  out  32  measured latency, zero-extended; all ones unless DONE
- `o_cal_done`  out  1  high in DONE
- `o_cal_error`  out  1  high in ERROR
- `o_aligned_valid`  out  1  delayed outputs are meaningful; equals `o_cal_done`

## Operation
- Counters and widths:
  - `arm_cnt` is ARM_W bits, free-running, wraps all-ones→0.
  - `lat` is clog2(MAX_LAT+1) bits.
- Drive register: `a_0 <= 0`, `b_0 <= 0` when state==ARM && &arm_cnt (marker). Otherwise `a_0 <= i_rand_a`, `b_0 <= i_rand_b`.
  - Exactly one marker is injected per calibration.
  - No zeros are forced after DONE.
- Delay line:
  - `tap[0] = a_0`; `tap[n] <= tap[n-1]` every cycle for n = 1..MAX_LAT. Same for b.
  - `o_drive_delayed_* = tap[L]` when DONE, else 0.
- FSM, one-hot, 5 states:
  - IDLE: go to ARM when `i_dut_out != 0`. This proves the DUT has flushed with random data.
  - ARM: go to COUNT when `&arm_cnt`. The marker loads on that same edge. `lat <= 0`.
  - COUNT:
    - If `i_dut_out == 0`: go to DONE, latch `L = lat`.
    - Else if `lat == MAX_LAT`: go to ERROR.
    - Else `lat <= lat + 1`.
  - DONE: hold.
  - ERROR: hold.
- Latency definition: `L` = cycles from the cycle `o_drive_a` shows the marker to the cycle `i_dut_out == 0`. A combinational DUT gives 0; a single-register DUT gives 1.
- `i_recal`=1 in any state: next state IDLE, `lat <= 0`, `L` cleared, `o_cal_done`/`o_aligned_valid`/`o_cal_error` drop next cycle.
- A random DUT result of 0 during COUNT gives an early (wrong) L. This is accepted at probability ~2^-WIDTH per cycle and is not detected.

## Timing
- Reset values, forced on the edge with `reset`=1:
  - state IDLE, `arm_cnt` 0, `lat` 0, `L` 0.
  - `a_0`, `b_0`, all taps 0.
  - `o_drive_*` 0, `o_drive_delayed_*` 0.
  - `o_dut_delay` 32'hFFFF_FFFF.
  - `o_cal_done`, `o_cal_error`, `o_aligned_valid` 0.
- `reset` overrides `i_recal`. Reset mid-COUNT discards the measurement.
- `o_drive_*` lag `i_rand_*` by 1 cycle.
- Outputs are registered or decoded from registered state only; no combinational path from `i_dut_out` to any output.
- COUNT→DONE at the edge where `i_dut_out==0` is sampled. `o_dut_delay` = L from the next cycle.
- `lat==MAX_LAT` with `i_dut_out==0` in the same cycle: DONE with L=MAX_LAT, not ERROR.
- Calibration time = IDLE wait + up to 2^ARM_W cycles in ARM + (L+1) cycles in COUNT.
- Once in DONE, `tap[L]` was loaded ≥L cycles earlier, so aligned data is valid immediately.

## Test plan
- DUT = 3-stage registered adder, WIDTH=32: after reset → DONE, `o_dut_delay`=3, and `o_drive_delayed_a+o_drive_delayed_b == i_dut_out` on every subsequent cycle for 1000 cycles.
- Combinational adder DUT → `o_dut_delay`=0. Delayed outputs equal `o_drive_*` each cycle.
- DUT pipeline depth 20 with MAX_LAT=15 → ERROR after COUNT spends 16 cycles. `o_cal_error`=1, `o_dut_delay`=32'hFFFF_FFFF, delayed outputs 0.
- DUT depth 15 (=MAX_LAT) → DONE, `o_dut_delay`=15, not ERROR.
- Depth 2 calibrated, then switch DUT to depth 5 and pulse `i_recal` 1 cycle → `o_cal_done` low next cycle, recalibrates to 5, alignment check passes.
- Assert `reset` mid-COUNT, then `i_recal` and `reset` together → all outputs at reset values next cycle. A later calibration yields the correct latency.
